// File: rtl/input_capture.sv
// Synchronised, debounced edge-capture input port with a level interrupt for the CPU.
// Build option: define INPUT_CAPTURE_BOTH_EDGES_EN to capture falling flips as events too.
module input_capture #(
    parameter int NCH        = 4,
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] pins,
    input  logic [7:0]     cmd,
    output logic [7:0]     data_out,
    output logic           irq
);

    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;
    logic [NCH-1:0] r_state;
    logic [CNT_W-1:0] r_cnt [NCH];
    logic [NCH-1:0] r_pending;
    logic [NCH-1:0] r_mask;
    logic           r_view;
    logic [7:0]     r_cmd_q;
    logic           r_irq;
    logic [7:0]     r_data_out;

    logic [NCH-1:0]   w_flip;
    logic [NCH-1:0]   w_state_next;
    logic [CNT_W-1:0] w_cnt_next [NCH];
    logic [NCH-1:0]   w_event;
    logic [NCH-1:0]   w_ack;
    logic [NCH-1:0]   w_mask_next;
    logic             w_view_next;
    logic [NCH-1:0]   w_pending_next;
    logic             w_irq_next;
    logic [NCH-1:0]   w_sel;
    logic             w_unused_cmd;

    assign w_unused_cmd = ^cmd;

    always_comb begin
        w_flip       = '0;
        w_state_next = r_state;
        for (int i = 0; i < NCH; i++) begin
            w_cnt_next[i] = '0;
            if (r_sync2[i] != r_state[i]) begin
                if (r_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    w_flip[i]       = 1'b1;
                    w_state_next[i] = r_sync2[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef INPUT_CAPTURE_BOTH_EDGES_EN
    assign w_event = w_flip & r_mask;
`else
    // After a flip the new level equals sync, so sync=1 marks a rising flip.
    assign w_event = w_flip & r_sync2 & r_mask;
`endif

    // A held command byte acts only in the cycle it first differs from last cycle's byte.
    always_comb begin
        w_ack       = '0;
        w_mask_next = r_mask;
        w_view_next = r_view;
        if (cmd != r_cmd_q) begin
            case (cmd[7:6])
                2'b01:   w_ack       = cmd[NCH-1:0];
                2'b10:   w_mask_next = cmd[NCH-1:0];
                2'b11:   w_view_next = cmd[0];
                default: ;
            endcase
        end
    end

    assign w_pending_next = (r_pending & ~w_ack) | w_event;
    assign w_irq_next     = |r_pending;
    assign w_sel          = w_view_next ? w_state_next : w_pending_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_state    <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
            r_view     <= 1'b0;
            r_cmd_q    <= '0;
            r_irq      <= 1'b0;
            r_data_out <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= pins;
            r_sync2    <= r_sync1;
            r_state    <= w_state_next;
            r_pending  <= w_pending_next;
            r_mask     <= w_mask_next;
            r_view     <= w_view_next;
            r_cmd_q    <= cmd;
            r_irq      <= w_irq_next;
            // Status byte tracks the values the other registers take on this edge.
            r_data_out <= {w_irq_next, 7'(w_sel)};
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign irq      = r_irq;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_input_capture.sv
// Bench for input_capture: directed pin/command vectors, a behavioural model
// compared every cycle, and hand-computed expectations at key points.
module tb_input_capture;

    localparam int NCH = 4;
    localparam int DEB = 4;
`ifdef INPUT_CAPTURE_BOTH_EDGES_EN
    localparam bit BOTH = 1'b1;
`else
    localparam bit BOTH = 1'b0;
`endif

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] pins  = '0;
    logic [7:0]     cmd   = '0;
    logic [7:0]     data_out;
    logic           irq;

    int checks = 0;
    int errors = 0;

    input_capture #(.NCH(NCH), .DEB_CYCLES(DEB), .CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .pins     (pins),
        .cmd      (cmd),
        .data_out (data_out),
        .irq      (irq)
    );

    always #30 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Behavioural model: pins reach the debouncer two samples late; a level is
    // accepted after DEB consecutive disagreeing samples.
    logic [NCH-1:0] m_d1 = '0, m_d2 = '0, m_state = '0, m_pending = '0, m_mask = '0;
    int             m_run [NCH];
    logic           m_view = 1'b0, m_irq = 1'b0;
    logic [7:0]     m_last = '0, m_data = '0;

    initial begin
        for (int c = 0; c < NCH; c++) m_run[c] = 0;
        forever begin
            logic [NCH-1:0] seen, ev, ack;
            logic           irq_n;
            @(posedge clk or posedge reset);
            if (reset) begin
                m_d1 = '0; m_d2 = '0; m_state = '0; m_pending = '0; m_mask = '0;
                m_view = 1'b0; m_irq = 1'b0; m_last = '0; m_data = '0;
                for (int c = 0; c < NCH; c++) m_run[c] = 0;
            end else begin
                seen = m_d2;
                m_d2 = m_d1;
                m_d1 = pins;
                ev   = '0;
                for (int c = 0; c < NCH; c++) begin
                    if (seen[c] == m_state[c]) m_run[c] = 0;
                    else begin
                        m_run[c] = m_run[c] + 1;
                        if (m_run[c] == DEB) begin
                            m_state[c] = seen[c];
                            m_run[c]   = 0;
                            if (m_mask[c] && (BOTH || seen[c])) ev[c] = 1'b1;
                        end
                    end
                end
                irq_n = |m_pending;
                ack   = '0;
                if (cmd != m_last) begin
                    case (cmd[7:6])
                        2'b01:   ack    = cmd[NCH-1:0];
                        2'b10:   m_mask = cmd[NCH-1:0];
                        2'b11:   m_view = cmd[0];
                        default: ;
                    endcase
                end
                m_last    = cmd;
                m_pending = (m_pending & ~ack) | ev;
                m_irq     = irq_n;
                m_data    = {irq_n, 7'b0} | 8'(m_view ? m_state : m_pending);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("model_irq", {7'b0, irq}, {7'b0, m_irq});
            check("model_data", data_out, m_data);
        end
    end

    initial begin
        #10 reset = 1'b0;

        // Idle after reset.
        for (int k = 0; k < 20; k++) begin
            step();
            check("idle_data", data_out, 8'h00);
            check("idle_irq", {7'b0, irq}, 8'h00);
        end

        // Masked rise on channel 0 and its exact latency.
        cmd = 8'h81;
        steps(2);
        pins = 4'b0001;
        steps(5);
        check("rise_e4_data", data_out, 8'h00);
        step();
        check("rise_e5_data", data_out, 8'h01);
        check("rise_e5_irq", {7'b0, irq}, 8'h00);
        step();
        check("rise_e6_data", data_out, 8'h81);
        check("rise_e6_irq", {7'b0, irq}, 8'h01);
        steps(13);

        // ACK clears pending, irq follows one cycle later; held command does nothing more.
        cmd = 8'h41;
        step();
        check("ack_data1", data_out, 8'h80);
        step();
        check("ack_data2", data_out, 8'h00);
        check("ack_irq2", {7'b0, irq}, 8'h00);
        steps(3);
        check("ack_hold", data_out, 8'h00);
        cmd = 8'h00;
        step();

        // Short pulse must not flip the debounced level.
        cmd = 8'h80;
        pins = 4'b0000;
        steps(8);
        cmd = 8'h81;
        step();
        pins = 4'b0001;
        steps(3);
        pins = 4'b0000;
        steps(10);
        check("glitch_irq", {7'b0, irq}, 8'h00);
        check("glitch_data", data_out, 8'h00);

        // Unmasked channel: no irq, but its level shows in the level view.
        pins = 4'b0010;
        steps(8);
        check("unmasked_irq", {7'b0, irq}, 8'h00);
        cmd = 8'hC1;
        step();
        check("view_levels", data_out, 8'h02);
        cmd = 8'hC0;
        step();
        check("view_pending", data_out, 8'h00);

        // Mask write keeps pending; ACK coinciding with a new rise keeps pending.
        cmd = 8'h81;
        pins = 4'b0011;
        steps(8);
        check("pend_set", data_out, 8'h81);
        cmd = 8'h80;
        step();
        check("mask_keeps", data_out, 8'h81);
        pins = 4'b0010;
        steps(8);
        check("fall_unmasked", data_out, 8'h81);
        cmd = 8'h81;
        step();
        pins = 4'b0011;
        steps(5);
        cmd = 8'h41;
        step();
        check("ack_vs_event_data", data_out, 8'h81);
        check("ack_vs_event_irq", {7'b0, irq}, 8'h01);
        step();
        check("ack_vs_event_hold", data_out, 8'h81);
        cmd = 8'h00;
        step();
        cmd = 8'h41;
        step();
        check("ack2_data1", data_out, 8'h80);
        step();
        check("ack2_data2", data_out, 8'h00);
        pins = 4'b0010;
        steps(9);
        check("fall_masked", data_out, BOTH ? 8'h81 : 8'h00);

        // Reset mid-stream with a line held high: level returns, no event.
        cmd = 8'h00;
        step();
        reset = 1'b1;
        #10;
        check("rst_data", data_out, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        reset = 1'b0;
        steps(8);
        cmd = 8'hC1;
        step();
        check("rst_levels", data_out, 8'h02);
        check("rst_no_irq", {7'b0, irq}, 8'h00);
        steps(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
